// File: rtl/cpu_run_ctrl.sv
// Run-control/debug unit for the single-cycle core: run/halt/step commands,
// PC breakpoints, cycle/retired counters and a registered register probe.
module cpu_run_ctrl #(
    parameter  int XLEN     = 32,
    parameter  int NUM_BP   = 2,
    parameter  int CNT_W    = 32,
    localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run_req,
    input  logic                     halt_req,
    input  logic                     step_req,
    input  logic [NUM_BP-1:0]        bp_en,
    input  logic [NUM_BP*XLEN-1:0]   bp_addr,
    input  logic [XLEN-1:0]          pc,
    input  logic [4:0]               reg_sel,
    input  logic [32*XLEN-1:0]       regs_flat,
    output logic                     cpu_enable,
    output logic                     halted,
    output logic [1:0]               halt_cause,
    output logic [BP_IDX_W-1:0]      bp_hit_idx,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         retired_count,
    output logic [XLEN-1:0]          probe_reg
);

    typedef enum logic [1:0] {
        ST_HALTED  = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STEP    = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_RESET = 2'b00;
    localparam logic [1:0] CAUSE_USER  = 2'b01;
    localparam logic [1:0] CAUSE_BP    = 2'b10;
    localparam logic [1:0] CAUSE_STEP  = 2'b11;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_run_q;
    logic                  r_halt_q;
    logic                  r_step_q;
    logic                  r_skip;
    logic                  w_skip_next;
    logic [1:0]            r_cause;
    logic [1:0]            w_cause_next;
    logic [BP_IDX_W-1:0]   r_bp_idx;
    logic [BP_IDX_W-1:0]   w_bp_idx_next;
    logic [CNT_W-1:0]      r_cycle;
    logic [CNT_W-1:0]      r_retired;
    logic [XLEN-1:0]       r_probe;

    logic                  w_run_cmd;
    logic                  w_halt_cmd;
    logic                  w_step_cmd;
    logic [NUM_BP-1:0]     w_bp_hit;
    logic                  w_bp_match;
    logic [BP_IDX_W-1:0]   w_match_idx;
    logic                  w_enable;
    logic [XLEN-1:0]       w_regs [32];

    // Rising-edge commands with priority halt > step > run.
    assign w_halt_cmd = halt_req & ~r_halt_q;
    assign w_step_cmd = step_req & ~r_step_q & ~w_halt_cmd;
    assign w_run_cmd  = run_req  & ~r_run_q  & ~w_halt_cmd & ~(step_req & ~r_step_q);

    generate
        for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
            assign w_bp_hit[gi] = bp_en[gi] & (pc == bp_addr[gi*XLEN +: XLEN]);
        end
        for (genvar gi = 0; gi < 32; gi++) begin : g_regs
            assign w_regs[gi] = regs_flat[gi*XLEN +: XLEN];
        end
    endgenerate

    assign w_bp_match = |w_bp_hit;

    always_comb begin
        w_match_idx = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (w_bp_hit[i]) begin
                w_match_idx = BP_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_HALTED;
            r_run_q  <= 1'b0;
            r_halt_q <= 1'b0;
            r_step_q <= 1'b0;
            r_skip   <= 1'b0;
            r_cause  <= CAUSE_RESET;
            r_bp_idx <= '0;
        end else begin
            r_state  <= w_state_next;
            r_run_q  <= run_req;
            r_halt_q <= halt_req;
            r_step_q <= step_req;
            r_skip   <= w_skip_next;
            r_cause  <= w_cause_next;
            r_bp_idx <= w_bp_idx_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_skip_next   = 1'b0;
        w_cause_next  = r_cause;
        w_bp_idx_next = r_bp_idx;
        w_enable      = 1'b0;
        case (r_state)
            ST_HALTED: begin
                if (w_step_cmd) begin
                    w_state_next = ST_STEP;
                end else if (w_run_cmd) begin
                    // Skip lets a resume execute the instruction parked on a breakpoint.
                    w_state_next = ST_RUNNING;
                    w_skip_next  = 1'b1;
                end
            end
            ST_STEP: begin
                w_enable     = 1'b1;
                w_state_next = ST_HALTED;
                w_cause_next = CAUSE_STEP;
            end
            ST_RUNNING: begin
                if (w_halt_cmd) begin
                    w_state_next = ST_HALTED;
                    w_cause_next = CAUSE_USER;
                end else if (w_bp_match & ~r_skip) begin
                    w_state_next  = ST_HALTED;
                    w_cause_next  = CAUSE_BP;
                    w_bp_idx_next = w_match_idx;
                end else begin
                    w_enable = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle   <= '0;
            r_retired <= '0;
            r_probe   <= '0;
        end else begin
            r_cycle <= r_cycle + CNT_W'(1);
            if (w_enable) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            r_probe <= w_regs[reg_sel];
        end
    end

    assign cpu_enable    = w_enable;
    assign halted        = (r_state == ST_HALTED);
    assign halt_cause    = r_cause;
    assign bp_hit_idx    = r_bp_idx;
    assign cycle_count   = r_cycle;
    assign retired_count = r_retired;
    assign probe_reg     = r_probe;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny core model that advances pc by 4
// on each enabled cycle; a second instance uses 4-bit counters to exercise wrap.
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          run_req;
    logic          halt_req;
    logic          step_req;
    logic [1:0]    bp_en;
    logic [63:0]   bp_addr;
    logic [31:0]   pc = '0;
    logic [4:0]    reg_sel;
    logic [1023:0] regs_flat;
    logic          pc_set;
    logic [31:0]   pc_set_val;

    logic          cpu_enable;
    logic          halted;
    logic [1:0]    halt_cause;
    logic [0:0]    bp_hit_idx;
    logic [31:0]   cycle_count;
    logic [31:0]   retired_count;
    logic [31:0]   probe_reg;

    logic          cpu_enable4;
    logic          halted4;
    logic [1:0]    halt_cause4;
    logic [0:0]    bp_hit_idx4;
    logic [3:0]    cycle_count4;
    logic [3:0]    retired_count4;
    logic [31:0]   probe_reg4;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    cpu_run_ctrl #(.XLEN(32), .NUM_BP(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .reg_sel(reg_sel), .regs_flat(regs_flat),
        .cpu_enable(cpu_enable), .halted(halted), .halt_cause(halt_cause),
        .bp_hit_idx(bp_hit_idx), .cycle_count(cycle_count), .retired_count(retired_count),
        .probe_reg(probe_reg)
    );

    cpu_run_ctrl #(.XLEN(32), .NUM_BP(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .reg_sel(reg_sel), .regs_flat(regs_flat),
        .cpu_enable(cpu_enable4), .halted(halted4), .halt_cause(halt_cause4),
        .bp_hit_idx(bp_hit_idx4), .cycle_count(cycle_count4), .retired_count(retired_count4),
        .probe_reg(probe_reg4)
    );

    // Core model follows the main instance's enable.
    always @(posedge clk) begin
        if (pc_set) pc <= pc_set_val;
        else if (cpu_enable) pc <= pc + 32'd4;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_set = 1'b1; pc_set_val = 32'h0;
        tick();
        rst = 1'b0; pc_set = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        bp_en = '0; bp_addr = '0; reg_sel = '0; pc_set = 1'b1; pc_set_val = 32'h0;
        for (int i = 0; i < 32; i++) begin
            regs_flat[i*32 +: 32] = (i == 5) ? 32'hDEADBEEF : i * 32'h01010101;
        end
        @(negedge clk);

        check("rst_enable",  cpu_enable,    0);
        check("rst_halted",  halted,        1);
        check("rst_cause",   halt_cause,    0);
        check("rst_bpidx",   bp_hit_idx,    0);
        check("rst_cycle",   cycle_count,   0);
        check("rst_retired", retired_count, 0);
        check("rst_probe",   probe_reg,     0);
        rst = 1'b0; pc_set = 1'b0; cyc = 0;

        // single step
        step_req = 1'b1;
        tick();
        check("step_en_on",  cpu_enable, 1);
        tick();
        check("step_en_off", cpu_enable, 0);
        check("step_halted", halted, 1);
        check("step_cause",  halt_cause, 3);
        check("step_ret",    retired_count, 1);
        check("step_pc",     pc, 32'h4);
        tick();
        check("step_held_ret", retired_count, 1);
        check("step_cycle",    cycle_count, cyc);
        step_req = 1'b0;

        // run into breakpoint 1 at 0xC
        do_reset();
        bp_en = 2'b10; bp_addr = {32'h0000000C, 32'hFFFFFFF0}; run_req = 1'b1;
        tick();
        check("run_en_pc0", cpu_enable, 1);
        tick(3);
        check("bp_pc",       pc, 32'hC);
        check("bp_en_off",   cpu_enable, 0);
        check("bp_ret_pre",  retired_count, 3);
        tick();
        check("bp_halted",   halted, 1);
        check("bp_cause",    halt_cause, 2);
        check("bp_idx",      bp_hit_idx, 1);
        check("bp_ret",      retired_count, 3);
        tick();
        check("bp_held_run", halted, 1);

        // resume over breakpoint
        run_req = 1'b0;
        tick();
        run_req = 1'b1;
        tick();
        check("resume_en",   cpu_enable, 1);
        tick();
        check("resume_pc",   pc, 32'h10);
        check("resume_ret",  retired_count, 4);
        check("resume_run",  halted, 0);

        // halt and step together while running
        halt_req = 1'b1; step_req = 1'b1;
        #1;
        check("halt_en_now", cpu_enable, 0);
        tick();
        check("halt_halted", halted, 1);
        check("halt_cause",  halt_cause, 1);
        check("halt_ret",    retired_count, 4);
        tick();
        check("halt_nostep", retired_count, 4);
        check("halt_pc",     pc, 32'h10);
        check("halt_cycle",  cycle_count, cyc);
        halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;

        // both breakpoints at 0x8: lowest index wins
        pc_set = 1'b1; pc_set_val = 32'h0; bp_en = 2'b11; bp_addr = {32'h8, 32'h8};
        tick();
        pc_set = 1'b0; run_req = 1'b1;
        tick(3);
        check("bp2_pc",     pc, 32'h8);
        check("bp2_en_off", cpu_enable, 0);
        tick();
        check("bp2_cause",  halt_cause, 2);
        check("bp2_idx",    bp_hit_idx, 0);
        check("bp2_ret",    retired_count, 6);

        // register probe
        reg_sel = 5'd5;
        #1;
        check("probe_lat",  probe_reg, 32'h0);
        tick();
        check("probe_x5",   probe_reg, 32'hDEADBEEF);
        reg_sel = 5'd31;
        tick();
        check("probe_x31",  probe_reg, 32'h1F1F1F1F);
        reg_sel = 5'd0;
        tick();
        check("probe_x0",   probe_reg, 32'h0);

        // step beats run when both arrive together
        run_req = 1'b0;
        tick();
        step_req = 1'b1; run_req = 1'b1;
        tick();
        check("prio_en",     cpu_enable, 1);
        tick();
        check("prio_halted", halted, 1);
        check("prio_cause",  halt_cause, 3);
        check("prio_ret",    retired_count, 7);
        tick();
        check("prio_stay",   halted, 1);
        step_req = 1'b0; run_req = 1'b0;

        // counter wrap on the 4-bit instance, then reset mid-run
        do_reset();
        bp_en = 2'b00; step_req = 1'b1;
        tick(2);
        step_req = 1'b0; run_req = 1'b1;
        tick();
        tick(16);
        check("wrap_ret32",  retired_count, 17);
        check("wrap_ret4",   retired_count4, 1);
        check("wrap_cyc4",   cycle_count4, 4'(cyc));
        check("wrap_en4",    cpu_enable4, 1);
        check("wrap_cause",  halt_cause, 3);
        rst = 1'b1;
        #1;
        check("arst_en",     cpu_enable, 0);
        check("arst_en4",    cpu_enable4, 0);
        check("arst_halted", halted, 1);
        check("arst_cause",  halt_cause, 0);
        check("arst_ret",    retired_count, 0);
        check("arst_cyc",    cycle_count, 0);
        check("arst_ret4",   retired_count4, 0);
        tick();
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
